// File: rtl/keypad_scanner.sv
// Scanned 4x4 active-low keypad reader with frame debounce and ghost rejection.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_FRAMES frames.
module keypad_scanner #(
  parameter int SCAN_DIV      = 1024,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_PRESS,
    S_REL
  } state_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [1:0]    r_acc_n;
  logic [3:0]    r_acc_code;
  logic          r_frm_ev, r_frm_one;
  logic [3:0]    r_frm_code;
  state_t        r_state;
  logic [3:0]    r_cand, r_cnt, r_rcnt;
  logic          r_held;
  logic [3:0]    r_code;
  logic          r_valid, r_ovr;

  logic       w_tick;
  logic [1:0] w_idx_nxt;
  logic [3:0] w_closed;
  logic [2:0] w_pop, w_sum;
  logic [1:0] w_tot, w_row_idx;
  logic [3:0] w_code_n;

  assign w_tick    = (r_div == DIV_MAX);
  assign w_idx_nxt = r_col_idx + 2'd1;
  assign w_closed  = ~r_sync2;
  assign w_pop     = {2'b0, w_closed[0]} + {2'b0, w_closed[1]}
                   + {2'b0, w_closed[2]} + {2'b0, w_closed[3]};
  assign w_sum     = {1'b0, r_acc_n} + w_pop;
  // switch count saturates at 2: anything beyond one key is ghosting
  assign w_tot     = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
  assign w_row_idx = {w_closed[3] | w_closed[2], w_closed[3] | w_closed[1]};
  assign w_code_n  = (w_pop == 3'd1) ? {r_col_idx, w_row_idx} : r_acc_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_div      <= '0;
      r_col_idx  <= 2'd0;
      r_col      <= 4'b1110;
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
      r_frm_ev   <= 1'b0;
      r_frm_one  <= 1'b0;
      r_frm_code <= 4'd0;
    end else begin
      r_sync1  <= row;
      r_sync2  <= r_sync1;
      r_frm_ev <= 1'b0;
      if (w_tick) begin
        r_div     <= '0;
        r_col_idx <= w_idx_nxt;
        r_col     <= ~(4'b0001 << w_idx_nxt);
        if (r_col_idx == 2'd3) begin
          r_frm_ev   <= 1'b1;
          r_frm_one  <= (w_tot == 2'd1);
          r_frm_code <= w_code_n;
          r_acc_n    <= 2'd0;
        end else begin
          r_acc_n    <= w_tot;
          r_acc_code <= w_code_n;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  logic       w_match, w_emit, w_rep_hit, w_emit_all;
  state_t     w_nxt;
  logic [3:0] w_cand_n, w_cnt_n, w_rcnt_n;

  assign w_match = r_frm_one && (r_frm_code == r_cand);

  always_comb begin
    w_nxt    = r_state;
    w_emit   = 1'b0;
    w_cand_n = r_cand;
    w_cnt_n  = r_cnt;
    w_rcnt_n = r_rcnt;
    if (r_frm_ev) begin
      unique case (r_state)
        S_IDLE: begin
          if (r_frm_one) begin
            w_cand_n = r_frm_code;
            w_cnt_n  = 4'd1;
            if (DB == 4'd1) begin
              w_nxt  = S_PRESS;
              w_emit = 1'b1;
            end else begin
              w_nxt  = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (w_match) begin
            w_cnt_n = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
            if (w_cnt_n >= DB) begin
              w_nxt  = S_PRESS;
              w_emit = 1'b1;
            end
          end else begin
            w_nxt = S_IDLE;
          end
        end
        S_PRESS: begin
          if (!w_match) begin
            w_rcnt_n = 4'd1;
            w_nxt    = (DB == 4'd1) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (w_match) begin
            w_nxt = S_PRESS;
          end else begin
            w_rcnt_n = (r_rcnt == 4'hF) ? r_rcnt : r_rcnt + 4'd1;
            if (w_rcnt_n >= DB) w_nxt = S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] r_rep;
  assign w_rep_hit = r_frm_ev && (r_state == S_PRESS) && w_match
                  && (r_rep == 16'(REPEAT_FRAMES - 1));

  // only consecutive stay-in-PRESSED frames advance the repeat count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep <= 16'd0;
    end else if (r_frm_ev) begin
      if ((r_state == S_PRESS) && w_match)
        r_rep <= w_rep_hit ? 16'd0 : r_rep + 16'd1;
      else
        r_rep <= 16'd0;
    end
  end
`else
  logic [15:0] w_unused_rep;
  assign w_unused_rep = 16'(REPEAT_FRAMES);
  assign w_rep_hit    = 1'b0;
`endif

  assign w_emit_all = w_emit | w_rep_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= 4'd0;
      r_rcnt  <= 4'd0;
      r_held  <= 1'b0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cand  <= w_cand_n;
      r_cnt   <= w_cnt_n;
      r_rcnt  <= w_rcnt_n;
      r_held  <= (w_nxt == S_PRESS) || (w_nxt == S_REL);
      if (r_valid && key_ready) begin
        if (w_emit_all) r_code <= w_cand_n;
        r_valid <= w_emit_all;
      end else if (w_emit_all) begin
        if (r_valid) begin
          r_ovr <= 1'b1;
        end else begin
          r_code  <= w_cand_n;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign overrun   = r_ovr;

endmodule
